// File: rtl/serial_frame_rx_if.sv
// Byte handshake between the serial receiver and its consumer.
// master: drives data_out/data_valid, takes data_ack; slave: the reverse.
interface serial_frame_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;

    modport master (
        output data_out,
        output data_valid,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ack
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial link receiver: idle 1, start 0, 8 data bits MSB first, stop 1.
// Ports: clock, reset (async, active high), rx_in (async serial line),
//   rx_en (receive enable), err_clr (clears sticky flags),
//   rx_bus (master: data_out, data_valid, data_ack handshake),
//   busy, frame_error, overrun_error, parity_error (sticky status).
// Define SERIAL_RX_PARITY_EN to add an even parity bit before the stop bit.
module serial_frame_rx #(
    parameter int BIT_TICKS = 106,
    parameter int CNT_W     = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic rx_in,
    input  logic rx_en,
    input  logic err_clr,
    serial_frame_rx_if.master rx_bus,
    output logic busy,
    output logic frame_error,
    output logic overrun_error,
    output logic parity_error
);

    localparam int HALF = BIT_TICKS / 2;
    localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP,
        R_RECOVER
    } state_t;

    state_t     state, state_n;
    logic       sync1, rx_s;
    logic [CNT_W-1:0] tick, tick_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       deliver;
    logic       frame_set;
    logic       ovr_set;
`ifdef SERIAL_RX_PARITY_EN
    logic       par_set;
`endif

    assign busy = (state != R_IDLE);

    // Two-flop synchroniser; idles high so reset never looks like a start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= R_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        deliver   = 1'b0;
        frame_set = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        if (!rx_en && state != R_IDLE) begin
            state_n = R_IDLE;
        end else begin
            unique case (state)
                R_IDLE: begin
                    if (rx_en && !rx_s) begin
                        state_n = R_START;
                        tick_n  = '0;
                    end
                end
                R_START: begin
                    // Mid-start sample: a line back high was only a glitch.
                    if (tick == TICK_HALF) begin
                        if (!rx_s) begin
                            state_n   = R_DATA;
                            tick_n    = '0;
                            bit_cnt_n = '0;
                        end else begin
                            state_n = R_IDLE;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
                R_DATA: begin
                    if (tick == TICK_LAST) begin
                        shift_n = {shift[6:0], rx_s};
                        tick_n  = '0;
                        if (bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_n = R_PARITY;
`else
                            state_n = R_STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                R_PARITY: begin
                    if (tick == TICK_LAST) begin
                        tick_n  = '0;
                        par_set = (rx_s != ^shift);
                        state_n = R_STOP;
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
`endif
                R_STOP: begin
                    if (tick == TICK_LAST) begin
                        tick_n = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_n = R_IDLE;
                        end else begin
                            frame_set = 1'b1;
                            state_n   = R_RECOVER;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
                R_RECOVER: begin
                    // A held-low break must go high before a new start.
                    if (rx_s) state_n = R_IDLE;
                end
                default: state_n = R_IDLE;
            endcase
        end
    end

    assign ovr_set = deliver && rx_bus.data_valid && !rx_bus.data_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick              <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            rx_bus.data_out   <= '0;
            rx_bus.data_valid <= 1'b0;
            frame_error       <= 1'b0;
            overrun_error     <= 1'b0;
        end else begin
            tick    <= tick_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            if (deliver && !ovr_set) begin
                rx_bus.data_out   <= shift;
                rx_bus.data_valid <= 1'b1;
            end else if (rx_bus.data_ack && rx_bus.data_valid) begin
                rx_bus.data_valid <= 1'b0;
            end
            if (frame_set)    frame_error <= 1'b1;
            else if (err_clr) frame_error <= 1'b0;
            if (ovr_set)      overrun_error <= 1'b1;
            else if (err_clr) overrun_error <= 1'b0;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        parity_error <= 1'b0;
        else if (par_set) parity_error <= 1'b1;
        else if (err_clr) parity_error <= 1'b0;
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx.
// Drives serial frames on rx_in and checks bytes, timing and flags.
module tb_serial_frame_rx;

    localparam int BT   = 106;
    localparam int HALF = BT / 2;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT  = 2 + HALF + 10 * BT;
`else
    localparam int LAT  = 2 + HALF + 9 * BT;
`endif

    logic clock = 1'b0;
    logic reset;
    logic rx_in;
    logic rx_en;
    logic err_clr;
    logic busy;
    logic frame_error;
    logic overrun_error;
    logic parity_error;

    serial_frame_rx_if bus ();

    serial_frame_rx #(.BIT_TICKS(BT), .CNT_W(10)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_in         (rx_in),
        .rx_en         (rx_en),
        .err_clr       (err_clr),
        .rx_bus        (bus),
        .busy          (busy),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .parity_error  (parity_error)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
`ifdef SERIAL_RX_PARITY_EN
    logic par_bad = 1'b0;
`endif

    // Caller is on a negedge; leaves rx_in at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        repeat (BT) @(negedge clock);
        for (int i = 7; i >= 0; i--) begin
            rx_in = d[i];
            repeat (BT) @(negedge clock);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx_in = (^d) ^ par_bad;
        repeat (BT) @(negedge clock);
`endif
        rx_in = stop;
        repeat (BT) @(negedge clock);
    endtask

    // Edges after t0 until data_valid is seen high; -1 if never.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 0; n < LAT + 200; n++) begin
            @(posedge clock);
            #1;
            if (bus.data_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_frame(input logic [7:0] d);
        int lat;
        logic [7:0] e;
        exp_q.push_back(d);
        fork
            send_frame(d, 1'b1);
            wait_valid(lat);
        join
        e = exp_q.pop_front();
        n_chk++;
        if (lat != LAT)
            $display("FAIL frame_lat: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_chk++;
        if (bus.data_out !== e)
            $display("FAIL frame_data: got %h want %h", bus.data_out, e);
        else n_pass++;
        bus.data_ack = 1'b1;
        @(posedge clock);
        #1;
        n_chk++;
        if (bus.data_valid !== 1'b0)
            $display("FAIL frame_ack: got %b want 0", bus.data_valid);
        else n_pass++;
        @(negedge clock);
        bus.data_ack = 1'b0;
        idle(10);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_in = 1'b1;
        rx_en = 1'b1;
        err_clr = 1'b0;
        bus.data_ack = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++;
        if ({bus.data_out, bus.data_valid, busy} !== 10'h0)
            $display("FAIL reset_out: got %h/%b/%b want 00/0/0",
                     bus.data_out, bus.data_valid, busy);
        else n_pass++;
        n_chk++;
        if ({frame_error, overrun_error, parity_error} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000",
                     {frame_error, overrun_error, parity_error});
        else n_pass++;
        reset = 1'b0;
        idle(5);
        n_chk++;
        if (busy !== 1'b0)
            $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic;
        int lat;
        logic [7:0] e;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_valid(lat);
                e = exp_q.pop_front();
                n_chk++;
                if (lat != LAT)
                    $display("FAIL basic_lat: got %0d want %0d", lat, LAT);
                else n_pass++;
                n_chk++;
                if (bus.data_out !== e)
                    $display("FAIL basic_data: got %h want %h",
                             bus.data_out, e);
                else n_pass++;
                repeat (5) @(negedge clock);
                bus.data_ack = 1'b1;
                @(posedge clock);
                #1;
                n_chk++;
                if (bus.data_valid !== 1'b0)
                    $display("FAIL basic_ack: got %b want 0", bus.data_valid);
                else n_pass++;
                @(negedge clock);
                bus.data_ack = 1'b0;
            end
        join
        idle(10);
        n_chk++;
        if ({frame_error, overrun_error, parity_error} !== 3'b000)
            $display("FAIL basic_flags: got %b want 000",
                     {frame_error, overrun_error, parity_error});
        else n_pass++;
    endtask

    task automatic test_glitch;
        rx_in = 1'b0;
        repeat (20) @(negedge clock);
        rx_in = 1'b1;
        repeat (30) @(negedge clock);
        n_chk++;
        if (busy !== 1'b1)
            $display("FAIL glitch_busy_hi: got %b want 1", busy);
        else n_pass++;
        repeat (10) @(negedge clock);
        n_chk++;
        if (busy !== 1'b0)
            $display("FAIL glitch_busy_lo: got %b want 0", busy);
        else n_pass++;
        repeat (BT * 10) @(negedge clock);
        n_chk++;
        if ({bus.data_valid, frame_error, overrun_error} !== 3'b000)
            $display("FAIL glitch_quiet: got %b want 000",
                     {bus.data_valid, frame_error, overrun_error});
        else n_pass++;
    endtask

    task automatic test_frame_error;
        send_frame(8'h3C, 1'b0);
        repeat (300) @(negedge clock);
        n_chk++;
        if ({frame_error, bus.data_valid, busy} !== 3'b101)
            $display("FAIL ferr_set: got fe/dv/busy=%b want 101",
                     {frame_error, bus.data_valid, busy});
        else n_pass++;
        idle(BT * 11);
        n_chk++;
        if ({bus.data_valid, busy, frame_error} !== 3'b001)
            $display("FAIL ferr_recover: got dv/busy/fe=%b want 001",
                     {bus.data_valid, busy, frame_error});
        else n_pass++;
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        n_chk++;
        if (frame_error !== 1'b0)
            $display("FAIL ferr_clr: got %b want 0", frame_error);
        else n_pass++;
    endtask

    task automatic test_overrun;
        int lat;
        logic [7:0] e;
        exp_q.push_back(8'h11);
        fork
            send_frame(8'h11, 1'b1);
            wait_valid(lat);
        join
        e = exp_q.pop_front();
        idle(5);
        send_frame(8'h22, 1'b1);
        idle(5);
        n_chk++;
        if ({bus.data_out, bus.data_valid, overrun_error} !== {e, 2'b11})
            $display("FAIL ovr_set: got %h/%b/%b want %h/1/1",
                     bus.data_out, bus.data_valid, overrun_error, e);
        else n_pass++;
        bus.data_ack = 1'b1;
        err_clr = 1'b1;
        @(negedge clock);
        bus.data_ack = 1'b0;
        err_clr = 1'b0;
        n_chk++;
        if ({bus.data_valid, overrun_error} !== 2'b00)
            $display("FAIL ovr_clr: got %b want 00",
                     {bus.data_valid, overrun_error});
        else n_pass++;
        idle(5);
        exp_q.push_back(8'h11);
        fork
            send_frame(8'h11, 1'b1);
            wait_valid(lat);
        join
        e = exp_q.pop_front();
        n_chk++;
        if (bus.data_out !== e)
            $display("FAIL ovr_first: got %h want %h", bus.data_out, e);
        else n_pass++;
        idle(5);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(posedge clock);
                repeat (LAT - 1) @(posedge clock);
                @(negedge clock);
                bus.data_ack = 1'b1;
                @(posedge clock);
                #1;
                e = exp_q.pop_front();
                n_chk++;
                if ({bus.data_out, bus.data_valid, overrun_error}
                    !== {e, 2'b10})
                    $display("FAIL ovr_ack: got %h/%b/%b want %h/1/0",
                             bus.data_out, bus.data_valid,
                             overrun_error, e);
                else n_pass++;
                @(negedge clock);
                bus.data_ack = 1'b0;
            end
        join
        bus.data_ack = 1'b1;
        @(negedge clock);
        bus.data_ack = 1'b0;
        idle(10);
    endtask

    task automatic test_abort(input bit use_reset);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BT + HALF) @(negedge clock);
                if (use_reset) reset = 1'b1;
                else           rx_en = 1'b0;
                @(posedge clock);
                #1;
                n_chk++;
                if (busy !== 1'b0)
                    $display("FAIL abort_busy(%0d): got %b want 0",
                             use_reset, busy);
                else n_pass++;
                @(negedge clock);
                reset = 1'b0;
                rx_en = 1'b1;
            end
        join
        idle(BT * 3);
        n_chk++;
        if ({bus.data_valid, frame_error} !== 2'b00)
            $display("FAIL abort_quiet(%0d): got %b want 00",
                     use_reset, {bus.data_valid, frame_error});
        else n_pass++;
        expect_frame(8'h81);
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity;
        par_bad = 1'b1;
        expect_frame(8'h07);
        n_chk++;
        if (parity_error !== 1'b1)
            $display("FAIL par_bad: got %b want 1", parity_error);
        else n_pass++;
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        par_bad = 1'b0;
        expect_frame(8'h07);
        n_chk++;
        if (parity_error !== 1'b0)
            $display("FAIL par_good: got %b want 0", parity_error);
        else n_pass++;
    endtask
`endif

    task automatic test_back_to_back;
        expect_frame(8'h00);
        expect_frame(8'hFF);
        expect_frame(8'h5A);
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL sb_empty: got %0d want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_in = 1'b1;
        rx_en = 1'b1;
        err_clr = 1'b0;
        reset = 1'b1;
        bus.data_ack = 1'b0;
        @(negedge clock);
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_abort(1'b1);
        test_abort(1'b0);
`ifdef SERIAL_RX_PARITY_EN
        test_parity;
`endif
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
